// File: rtl/xmint_pkg.sv
// Shared constants, response payload and the SECDED(39,32) check-bit encoder
// used by both this memory and the core-side integrity checker.
package xmint_pkg;
  localparam int XLEN   = 32;
  localparam int INTG_W = 7;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] data;
  } resp_t;

  // Hsiao code: every data column has odd weight, so a double error never
  // aliases to a single-bit syndrome on the checker side.
  function automatic logic [INTG_W-1:0] intg_encode(input logic [XLEN-1:0] d);
    logic [INTG_W-1:0] c;
    c[0] = ^(d & 32'h2606_BD25);
    c[1] = ^(d & 32'hDEBA_8050);
    c[2] = ^(d & 32'h413D_89AA);
    c[3] = ^(d & 32'h3123_4ED1);
    c[4] = ^(d & 32'hC2C1_323B);
    c[5] = ^(d & 32'h2DCC_624C);
    c[6] = ^(d & 32'h9850_5586);
    return c;
  endfunction
endpackage

// File: rtl/xmint_resp_pipe.sv
// Fixed-depth valid/payload delay line; reset empties every stage.
module xmint_resp_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 33
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);
  logic [DEPTH:1]        vld_pipe;
  logic [DEPTH:1][W-1:0] dat_pipe;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_vld;
      dat_pipe[1] <= in_data;
      for (int i = 2; i <= DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_vld  = vld_pipe[DEPTH];
  assign out_data = dat_pipe[DEPTH];
endmodule

// File: rtl/xmint_dmem_resp.sv
// Local data memory with integrity-checked writes and a fixed-latency,
// in-order response path.
module xmint_dmem_resp
  import xmint_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [INTG_W-1:0] wdata_intg_i,
  output logic              rvalid_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic [INTG_W-1:0] rdata_intg_o,
  output logic              err_o,
  input  logic              stall_i
);
  localparam int IDXW = $clog2(MEM_WORDS);

  logic [XLEN-1:0] mem [MEM_WORDS];
  logic            acc;
  logic [XLEN-1:0] off;
  logic [IDXW-1:0] idx;
  logic            in_range;
  logic            err;
  resp_t           resp_d;
  resp_t           resp_q;
  logic            vld_q;

  assign gnt_o = req_i & ~stall_i & ~rst_i;
  assign acc   = req_i & gnt_o;

  // BASE_ADDR is window-aligned, so the offset's low bits equal addr_i's and
  // anything above the index field means outside the window (incl. below base).
  assign off      = addr_i - BASE_ADDR;
  assign idx      = off[IDXW+1:2];
  assign in_range = (off[XLEN-1:IDXW+2] == '0);
  assign err      = (off[1:0] != 2'b00) | ~in_range
                  | (we_i & (wdata_intg_i != intg_encode(wdata_i)));

  always_ff @(posedge clk_i) begin
    if (acc & we_i & ~err) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    resp_d.err  = err;
    resp_d.data = (we_i | err) ? '0 : mem[idx];
  end

  xmint_resp_pipe #(
    .DEPTH (LATENCY),
    .W     ($bits(resp_t))
  ) u_pipe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .in_vld   (acc),
    .in_data  (resp_d),
    .out_vld  (vld_q),
    .out_data (resp_q)
  );

  // Outputs are forced quiet during reset even though the pipe clears only
  // on the reset edge.
  assign rvalid_o     = vld_q & ~rst_i;
  assign err_o        = rvalid_o & resp_q.err;
  assign rdata_o      = (rvalid_o & ~resp_q.err) ? resp_q.data : '0;
  assign rdata_intg_o = intg_encode(rdata_o);
endmodule

// File: tb/tb_xmint_dmem_resp.sv
// Randomised scoreboard bench for xmint_dmem_resp with a word-array reference.
module tb_xmint_dmem_resp;
  localparam int          MW   = 64;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          LAT  = 3;
  localparam bit [31:0] HMASK [7] = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA,
                                      32'h31234ED1, 32'hC2C1323B, 32'h2DCC624C,
                                      32'h98505586};

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = 4'h0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [6:0]  wdata_intg_i = '0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [6:0]  rdata_intg_o;
  logic        err_o;
  logic        stall_i = 1'b0;

  int nvec = 0, nerr = 0, cyc = 0, nresp = 0, stall_mode = 0;
  bit [31:0] ref_mem [MW];

  typedef struct { bit err; bit [31:0] data; int cyc; } exp_t;
  exp_t sb[$];

  xmint_dmem_resp #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
    .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .wdata_intg_i(wdata_intg_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rdata_intg_o(rdata_intg_o),
    .err_o(err_o), .stall_i(stall_i));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (stall_mode)
      0:       stall_i = 1'b0;
      1:       stall_i = ~stall_i;
      default: stall_i = ($urandom_range(0, 3) == 0);
    endcase
  end

  function automatic bit [6:0] ref_intg(bit [31:0] d);
    bit [6:0] r = '0;
    for (int j = 0; j < 7; j++)
      for (int i = 0; i < 32; i++)
        if (HMASK[j][i] && d[i]) r[j] = ~r[j];
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: all output checks happen on the falling edge.
  always @(negedge clk) begin
    chk("gnt", gnt_o, req_i & ~stall_i & ~rst_i);
    if (rst_i) begin
      chk("rst_rvalid", rvalid_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_intg", rdata_intg_o, ref_intg(32'h0));
      sb.delete();
    end else if (rvalid_o) begin
      if (sb.size() == 0) chk("rvalid_spurious", rvalid_o, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        nresp++;
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_err", err_o, e.err);
        chk("resp_rdata", rdata_o, e.data);
        chk("resp_intg", rdata_intg_o, ref_intg(e.data));
      end
    end else begin
      chk("idle_err", err_o, 0);
      chk("idle_rdata", rdata_o, 0);
      chk("idle_intg", rdata_intg_o, ref_intg(32'h0));
      if (sb.size() != 0 && cyc > sb[0].cyc) begin
        chk("resp_missing", rvalid_o, 1);
        void'(sb.pop_front());
      end
    end
  end

  // Issue one request; on grant, apply the reference rules and queue the response.
  task automatic xact(bit we, bit [3:0] be, bit [31:0] addr, bit [31:0] wd, bit [6:0] wi);
    bit got = 0;
    exp_t e;
    req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wd; wdata_intg_i = wi;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (gnt_o) begin got = 1; break; end
    end
    if (!got) begin
      chk("gnt_timeout", gnt_o, 1);
      req_i = 1'b0;
      return;
    end
    e.err  = (addr[1:0] != 0) || (addr < BASE) || (addr >= BASE + MW * 4)
          || (we && wi != ref_intg(wd));
    e.data = '0;
    if (!e.err) begin
      int w = int'((addr - BASE) >> 2);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
      end else e.data = ref_mem[w];
    end
    e.cyc = cyc + LAT;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    req_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base_cnt;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    for (int i = 0; i < MW; i++) begin
      bit [31:0] d;
      d = $urandom;
      xact(1, 4'hF, BASE + 32'(i * 4), d, ref_intg(d));
    end
    idle(2);

    // Full write/read, partial-byte merge, empty byte-enable
    xact(1, 4'hF, BASE + 32'h10, 32'hCAFEBABE, ref_intg(32'hCAFEBABE));
    xact(0, 4'hF, BASE + 32'h10, 32'h0, 7'h0);
    idle(1);
    xact(1, 4'b0101, BASE + 32'h10, 32'h11223344, ref_intg(32'h11223344));
    xact(0, 4'hF, BASE + 32'h10, 32'h0, 7'h0);
    xact(1, 4'h0, BASE + 32'h14, 32'h01234567, ref_intg(32'h01234567));
    xact(0, 4'hF, BASE + 32'h14, 32'h0, 7'h0);

    // Error cases: misaligned, window edges, bad integrity (storage untouched)
    xact(0, 4'hF, BASE + 32'h2, 32'h0, 7'h0);
    xact(0, 4'hF, BASE + MW * 4, 32'h0, 7'h0);
    xact(0, 4'hF, BASE - 32'h4, 32'h0, 7'h0);
    xact(0, 4'hF, BASE + MW * 4 - 4, 32'h0, 7'h0);
    xact(1, 4'hF, BASE + 32'h10, 32'h55AA55AA, ref_intg(32'h55AA55AA) ^ 7'h01);
    xact(0, 4'hF, BASE + 32'h10, 32'h0, 7'h0);
    idle(LAT + 2);

    // Back-to-back reads under a toggling stall
    base_cnt = nresp;
    stall_mode = 1;
    for (int k = 0; k < 8; k++) xact(0, 4'hF, BASE + 32'(k * 4), 32'h0, 7'h0);
    stall_mode = 0;
    idle(LAT + 3);
    chk("stall_rvalid_cnt", nresp - base_cnt, 8);

    // Reset while responses are in flight; one is already at the output
    xact(0, 4'hF, BASE + 32'h0, 32'h0, 7'h0);
    xact(0, 4'hF, BASE + 32'h4, 32'h0, 7'h0);
    xact(0, 4'hF, BASE + 32'h8, 32'h0, 7'h0);
    idle(1);
    req_i = 1'b1; we_i = 1'b0; addr_i = BASE; rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    idle(LAT + 3);
    xact(0, 4'hF, BASE + 32'h10, 32'h0, 7'h0);
    xact(0, 4'hF, BASE + 32'h0, 32'h0, 7'h0);
    idle(1);

    // Randomised traffic with random stalls
    stall_mode = 2;
    for (int n = 0; n < 300; n++) begin
      bit        we;
      bit [31:0] a, d;
      bit [6:0]  wi;
      int        sel;
      we  = $urandom_range(0, 1);
      d   = $urandom;
      sel = $urandom_range(0, 11);
      case (sel)
        0:       a = BASE + $urandom_range(0, MW * 4 - 1);
        1:       a = $urandom;
        2:       a = BASE + MW * 4 + 32'(4 * $urandom_range(0, 3));
        3:       a = BASE - 32'h4;
        default: a = BASE + 32'(4 * $urandom_range(0, MW - 1));
      endcase
      wi = ref_intg(d);
      if ($urandom_range(0, 7) == 0) wi[$urandom_range(0, 6)] ^= 1'b1;
      xact(we, 4'($urandom_range(0, 15)), a, d, wi);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    stall_mode = 0;
    idle(LAT + 4);
    chk("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
